udp_dram_reader: RTL and testbench



---
 rtl/udp_bridge_pkg.sv | 38 +++
 rtl/udp_reply_hdr.sv | 33 +++
 rtl/udp_dram_reader.sv | 227 ++++++++++++++++++++++
 tb/tb_udp_dram_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_bridge_pkg.sv
// udp_bridge_pkg
// Shared definitions for the UDP <-> DRAM bridge blocks.
// Holds the reader FSM state encoding, the positions of the UDP header words
// captured from the RX stream, the read/write flag carried in bit 0 of the
// address word, and the layout of the DRAM control word that both the read
// and write paths drive.
package udp_bridge_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_LEN,
        S_DRAIN,
        S_CMD,
        S_TXREQ,
        S_TXHDR,
        S_TXADDR,
        S_TXDATA
    } state_t;

    // Order of the header words as they arrive on the RX stream
    localparam int HDR_SRC_IP  = 0;
    localparam int HDR_DST_IP  = 1;
    localparam int HDR_PORTS   = 2;
    localparam int HDR_PAYLOAD = 3;
    localparam int HDR_WORDS   = 4;

    // Bit 0 of the address word selects the request direction
    localparam logic FLAG_READ  = 1'b0;
    localparam logic FLAG_WRITE = 1'b1;

    // DRAM control word: {len-1, byte address}
    localparam int CTRL_ADDR_W = 32;
    localparam int CTRL_LEN_W  = 8;
    localparam int CTRL_W      = CTRL_LEN_W + CTRL_ADDR_W;

endpackage

// File: rtl/udp_reply_hdr.sv
// udp_reply_hdr
// Combinational builder of the four reply header words. The reply goes back
// to the requester, so source and destination IP and ports are swapped, and
// the payload byte count covers the echoed address word plus N data words.
// Ports:
//   src_ip, dst_ip, ports : header words captured from the request
//   n                     : number of data words in the reply (1..256)
//   sel                   : which reply header word to produce (0..3)
//   word                  : selected reply header word
module udp_reply_hdr (
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [31:0] ports,
    input  logic [8:0]  n,
    input  logic [1:0]  sel,
    output logic [31:0] word
);

    logic [31:0] reply_bytes;

    // Reply payload is the address echo plus N data words, 4 bytes each
    always_comb begin
        reply_bytes = ({23'd0, n} + 32'd1) << 2;
        word        = '0;
        case (sel)
            2'd0:    word = dst_ip;
            2'd1:    word = src_ip;
            2'd2:    word = {ports[15:0], ports[31:16]};
            default: word = reply_bytes;
        endcase
    end

endmodule

// File: rtl/udp_dram_reader.sv
// udp_dram_reader
// Read-side responder of the UDP <-> DRAM bridge. Parses a read request from
// the RX stream, issues one DRAM read command, then sends a UDP reply made of
// four header words, an echo of the address word and N words popped from the
// DRAM read FIFO. Write requests are left to the write path that shares RX.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   r_req, r_enable, r_data    : RX stream (r_enable high for a whole packet)
//   r_ack                      : RX accept, tied high
//   w_req, w_ack               : TX request / grant handshake
//   w_enable, w_data           : TX word valid and data
//   rd_ctrl_in, rd_ctrl_we     : DRAM read command and its one-cycle strobe
//   rd_data, rd_data_valid     : DRAM read FIFO head (first-word-fall-through)
//   rd_data_re                 : DRAM read FIFO pop
//   drop_cnt                   : saturating count of rejected read requests
module udp_dram_reader
    import udp_bridge_pkg::*;
#(
    parameter int          MAX_LEN  = 256,
    parameter int          TIMEOUT  = 1048576,
    parameter logic [31:0] PAD_WORD = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_req,
    input  logic              r_enable,
    output logic              r_ack,
    input  logic [31:0]       r_data,
    output logic              w_req,
    output logic              w_enable,
    input  logic              w_ack,
    output logic [31:0]       w_data,
    output logic [CTRL_W-1:0] rd_ctrl_in,
    output logic              rd_ctrl_we,
    input  logic [31:0]       rd_data,
    input  logic              rd_data_valid,
    output logic              rd_data_re,
    output logic [15:0]       drop_cnt
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          next_state;
    logic [31:0]     hdr [HDR_WORDS];
    logic [31:0]     addr_word;
    logic [8:0]      n;
    logic            go;
    logic [1:0]      idx;
    logic [8:0]      data_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;
    logic            r_enable_q;
    logic            rx_start;
    logic            len_bad;
    logic            send;
    logic            last_data;
    logic [31:0]     hdr_word;
    logic            unused_inputs;

    // A packet only starts on a rising r_enable, so the tail of a packet that
    // arrived while a reply was in flight is never parsed as a new request.
    assign rx_start  = r_enable && !r_enable_q;
    assign len_bad   = (r_data[8:0] == 9'd0) || (r_data[8:0] > 9'(MAX_LEN));
    assign send      = (state == S_TXDATA) && (rd_data_valid || timed_out);
    assign last_data = (data_cnt == n - 9'd1);

    assign r_ack         = 1'b1;
    assign unused_inputs = ^{r_req, hdr[HDR_PAYLOAD]};

    udp_reply_hdr u_reply_hdr (
        .src_ip (hdr[HDR_SRC_IP]),
        .dst_ip (hdr[HDR_DST_IP]),
        .ports  (hdr[HDR_PORTS]),
        .n      (n),
        .sel    (idx),
        .word   (hdr_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a packet that ends before its length word is dropped
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (rx_start) next_state = S_HDR;
            S_HDR:    if (!r_enable) next_state = S_IDLE;
                      else if (idx == 2'd3) next_state = S_ADDR;
            S_ADDR:   if (!r_enable) next_state = S_IDLE;
                      else if (r_data[0] == FLAG_READ) next_state = S_LEN;
                      else next_state = S_DRAIN;
            S_LEN:    if (!r_enable) next_state = S_IDLE;
                      else next_state = S_DRAIN;
            S_DRAIN:  if (!r_enable) next_state = go ? S_CMD : S_IDLE;
            S_CMD:    next_state = S_TXREQ;
            S_TXREQ:  if (w_ack) next_state = S_TXHDR;
            S_TXHDR:  if (idx == 2'd3) next_state = S_TXADDR;
            S_TXADDR: next_state = S_TXDATA;
            S_TXDATA: if (send && last_data) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Request capture, word counters and the FIFO-starvation timeout.
    // idx walks the RX header words and is reused to walk the TX header words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_WORDS; i++) begin
                hdr[i] <= '0;
            end
            addr_word  <= '0;
            n          <= '0;
            go         <= 1'b0;
            idx        <= '0;
            data_cnt   <= '0;
            to_cnt     <= '0;
            timed_out  <= 1'b0;
            r_enable_q <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            r_enable_q <= r_enable;
            case (state)
                S_IDLE: begin
                    if (rx_start) begin
                        hdr[HDR_SRC_IP] <= r_data;
                        idx             <= 2'd1;
                        go              <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (r_enable) begin
                        hdr[idx] <= r_data;
                        idx      <= idx + 2'd1;
                    end
                end
                S_ADDR: begin
                    if (r_enable) begin
                        addr_word <= r_data;
                    end
                end
                S_LEN: begin
                    if (r_enable) begin
                        n <= r_data[8:0];
                        if (len_bad) begin
                            if (drop_cnt != 16'hFFFF) begin
                                drop_cnt <= drop_cnt + 16'd1;
                            end
                        end else begin
                            go <= 1'b1;
                        end
                    end
                end
                S_TXREQ:  idx <= 2'd0;
                S_TXHDR:  idx <= idx + 2'd1;
                S_TXADDR: data_cnt <= '0;
                S_TXDATA: begin
                    if (send) begin
                        data_cnt <= data_cnt + 9'd1;
                    end
                end
                default: ;
            endcase

            // Once TIMEOUT empty cycles have passed since the last pop, the
            // rest of the reply is padded and late FIFO data is left alone.
            if (state != S_TXDATA) begin
                to_cnt    <= '0;
                timed_out <= 1'b0;
            end else if (rd_data_re) begin
                to_cnt <= '0;
            end else if (!rd_data_valid && !timed_out) begin
                if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timed_out <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

    // Outputs are decoded from the state so an asynchronous reset clears
    // every strobe immediately.
    always_comb begin
        w_req      = 1'b0;
        w_enable   = 1'b0;
        w_data     = '0;
        rd_ctrl_we = 1'b0;
        rd_ctrl_in = '0;
        rd_data_re = 1'b0;
        case (state)
            S_CMD: begin
                rd_ctrl_we = 1'b1;
                rd_ctrl_in = {CTRL_LEN_W'(n - 9'd1), addr_word[30:1], 2'b00};
            end
            S_TXREQ: begin
                w_req = 1'b1;
            end
            S_TXHDR: begin
                w_enable = 1'b1;
                w_data   = hdr_word;
            end
            S_TXADDR: begin
                w_enable = 1'b1;
                w_data   = addr_word;
            end
            S_TXDATA: begin
                if (timed_out) begin
                    w_enable = 1'b1;
                    w_data   = PAD_WORD;
                end else if (rd_data_valid) begin
                    w_enable   = 1'b1;
                    w_data     = rd_data;
                    rd_data_re = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_dram_reader.sv
// tb_udp_dram_reader
// Directed bench for udp_dram_reader: read requests of several lengths, a
// write request, rejected lengths, a trickling FIFO, a FIFO timeout with
// padding and an asynchronous reset in the middle of a reply.
module tb_udp_dram_reader;

    localparam logic [31:0] SRC   = 32'h0A00_0001;
    localparam logic [31:0] DST   = 32'h0A00_0002;
    localparam logic [31:0] PORTS = 32'h1234_5678;
    localparam logic [31:0] PLEN  = 32'h0000_0008;
    localparam logic [31:0] PAD   = 32'hDEAD_BEEF;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic        r_req         = 1'b0;
    logic        r_enable      = 1'b0;
    logic [31:0] r_data        = '0;
    logic        w_ack         = 1'b0;
    logic [31:0] rd_data       = '0;
    logic        rd_data_valid = 1'b0;
    logic        r_ack;
    logic        w_req;
    logic        w_enable;
    logic [31:0] w_data;
    logic [39:0] rd_ctrl_in;
    logic        rd_ctrl_we;
    logic        rd_data_re;
    logic [15:0] drop_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fall_cyc = 0;
    int          ack_cyc  = -1;
    int          cmd_cyc  = -1;
    int          cmd_cnt  = 0;
    int          wreq_cycles = 0;
    logic [39:0] last_cmd = '0;
    logic [31:0] fifo_q[$];
    logic [31:0] sched_dat[$];
    int          sched_cyc[$];
    logic [31:0] exp_data[$];
    logic [31:0] tx_q[$];
    int          tx_cyc[$];

    always #5 clk = ~clk;

    udp_dram_reader #(
        .MAX_LEN  (256),
        .TIMEOUT  (16),
        .PAD_WORD (PAD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r_req         (r_req),
        .r_enable      (r_enable),
        .r_ack         (r_ack),
        .r_data        (r_data),
        .w_req         (w_req),
        .w_enable      (w_enable),
        .w_ack         (w_ack),
        .w_data        (w_data),
        .rd_ctrl_in    (rd_ctrl_in),
        .rd_ctrl_we    (rd_ctrl_we),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_data_re    (rd_data_re),
        .drop_cnt      (drop_cnt)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fifo();
        rd_data_valid = (fifo_q.size() > 0);
        rd_data       = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    endtask

    // One clock: log outputs mid-cycle, then update the FIFO model after the edge
    task automatic tick();
        logic pop;
        #1;
        if (w_enable) begin
            tx_q.push_back(w_data);
            tx_cyc.push_back(cyc);
        end
        if (rd_ctrl_we) begin
            cmd_cnt++;
            last_cmd = rd_ctrl_in;
            cmd_cyc  = cyc;
        end
        if (w_req) wreq_cycles++;
        pop = rd_data_re;
        @(posedge clk);
        #1;
        cyc++;
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (sched_cyc.size() > 0 && sched_cyc[0] <= cyc) begin
            fifo_q.push_back(sched_dat.pop_front());
            void'(sched_cyc.pop_front());
        end
        refresh_fifo();
    endtask

    task automatic clear_log();
        tx_q.delete();
        tx_cyc.delete();
        cmd_cnt     = 0;
        wreq_cycles = 0;
        ack_cyc     = -1;
        cmd_cyc     = -1;
        last_cmd    = '0;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr_w, input logic [31:0] len_w);
        logic [31:0] words [6];
        words = '{SRC, DST, PORTS, PLEN, addr_w, len_w};
        for (int i = 0; i < 6; i++) begin
            r_req    = 1'b1;
            r_enable = 1'b1;
            r_data   = words[i];
            tick();
        end
        r_req    = 1'b0;
        r_enable = 1'b0;
        r_data   = '0;
        fall_cyc = cyc;
        tick();
    endtask

    // Grant TX after ack_delay cycles of w_req, then collect total TX words
    task automatic run_reply(input int total, input int ack_delay);
        int guard;
        guard = 0;
        while (!w_req && guard < 50) begin
            tick();
            guard++;
        end
        repeat (ack_delay) tick();
        w_ack   = 1'b1;
        ack_cyc = cyc;
        tick();
        w_ack = 1'b0;
        guard = 0;
        while (tx_q.size() < total && guard < 1000) begin
            tick();
            guard++;
        end
        check_output("reply_within_budget", 64'(tx_q.size() >= total), 64'd1);
        repeat (3) tick();
    endtask

    task automatic check_reply(input string tag, input int n, input logic [31:0] addr_w);
        check_output({tag, "_word_count"}, 64'(tx_q.size()), 64'(5 + n));
        if (tx_q.size() >= 5 + n) begin
            check_output({tag, "_hdr_dst"}, tx_q[0], DST);
            check_output({tag, "_hdr_src"}, tx_q[1], SRC);
            check_output({tag, "_hdr_ports"}, tx_q[2], 32'h5678_1234);
            check_output({tag, "_hdr_bytes"}, tx_q[3], 32'(4 * (n + 1)));
            check_output({tag, "_addr_echo"}, tx_q[4], addr_w);
            for (int i = 0; i < n; i++) begin
                check_output($sformatf("%s_data%0d", tag, i), tx_q[5 + i], exp_data[i]);
            end
            check_output({tag, "_first_hdr_latency"}, 64'(tx_cyc[0]), 64'(ack_cyc + 1));
            check_output({tag, "_hdr_back_to_back"}, 64'(tx_cyc[4] - tx_cyc[0]), 64'd4);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] udp_dram_reader directed test");
        refresh_fifo();

        // Reset values
        repeat (2) tick();
        check_output("rst_r_ack", r_ack, 1);
        check_output("rst_w_req", w_req, 0);
        check_output("rst_w_enable", w_enable, 0);
        check_output("rst_w_data", w_data, 0);
        check_output("rst_rd_ctrl_we", rd_ctrl_we, 0);
        check_output("rst_rd_ctrl_in", rd_ctrl_in, 0);
        check_output("rst_rd_data_re", rd_data_re, 0);
        check_output("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: read N=4 from 0x200, FIFO preloaded
        $display("[TB] read N=4, preloaded FIFO");
        clear_log();
        exp_data = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        fifo_q = exp_data;
        refresh_fifo();
        apply_stimulus(32'h0000_0200, 32'd4);
        run_reply(9, 2);
        check_output("t1_cmd_count", 64'(cmd_cnt), 64'd1);
        check_output("t1_cmd_value", last_cmd, 40'h03_0000_0400);
        check_output("t1_cmd_latency", 64'(cmd_cyc), 64'(fall_cyc + 1));
        check_output("t1_w_req_cycles", 64'(wreq_cycles), 64'd3);
        check_reply("t1", 4, 32'h0000_0200);
        if (tx_cyc.size() >= 9)
            check_output("t1_data_back_to_back", 64'(tx_cyc[8] - tx_cyc[0]), 64'd8);
        check_output("t1_fifo_drained", 64'(fifo_q.size()), 64'd0);
        check_output("t1_drop_cnt", drop_cnt, 0);

        // 2: write request is ignored
        $display("[TB] write request");
        clear_log();
        apply_stimulus(32'h0000_0201, 32'd4);
        repeat (20) tick();
        check_output("t2_no_cmd", 64'(cmd_cnt), 64'd0);
        check_output("t2_no_w_req", 64'(wreq_cycles), 64'd0);
        check_output("t2_no_tx", 64'(tx_q.size()), 64'd0);
        check_output("t2_drop_cnt", drop_cnt, 0);

        // 3: rejected lengths N=0 and N=257
        $display("[TB] rejected lengths");
        clear_log();
        apply_stimulus(32'h0000_0300, 32'd0);
        repeat (5) tick();
        check_output("t3_drop_after_n0", drop_cnt, 1);
        apply_stimulus(32'h0000_0300, 32'd257);
        repeat (5) tick();
        check_output("t3_drop_after_n257", drop_cnt, 2);
        check_output("t3_no_cmd", 64'(cmd_cnt), 64'd0);
        check_output("t3_no_w_req", 64'(wreq_cycles), 64'd0);

        // 3b: largest accepted length N=256
        $display("[TB] read N=256");
        clear_log();
        exp_data.delete();
        for (int i = 0; i < 256; i++) exp_data.push_back(32'hC000_0000 + 32'(i));
        fifo_q = exp_data;
        refresh_fifo();
        apply_stimulus(32'h0000_0800, 32'd256);
        run_reply(261, 1);
        check_output("t3b_cmd_count", 64'(cmd_cnt), 64'd1);
        check_output("t3b_cmd_value", last_cmd, 40'hFF_0000_1000);
        check_reply("t3b", 256, 32'h0000_0800);
        check_output("t3b_drop_cnt", drop_cnt, 2);

        // 4: FIFO data trickles in every 5 cycles
        $display("[TB] read N=3, slow FIFO");
        clear_log();
        exp_data = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
        apply_stimulus(32'h0000_1000, 32'd3);
        for (int i = 0; i < 3; i++) begin
            sched_cyc.push_back(fall_cyc + 10 + 5 * i);
            sched_dat.push_back(exp_data[i]);
        end
        run_reply(8, 0);
        check_output("t4_cmd_value", last_cmd, 40'h02_0000_2000);
        check_reply("t4", 3, 32'h0000_1000);
        if (tx_cyc.size() >= 8) begin
            check_output("t4_data0_cycle", 64'(tx_cyc[5]), 64'(fall_cyc + 10));
            check_output("t4_data1_cycle", 64'(tx_cyc[6]), 64'(fall_cyc + 15));
            check_output("t4_data2_cycle", 64'(tx_cyc[7]), 64'(fall_cyc + 20));
        end

        // 5: one FIFO word then timeout padding after 16 empty cycles
        $display("[TB] read N=2, FIFO timeout");
        clear_log();
        exp_data = '{32'hC5C5_0001, PAD};
        fifo_q = '{32'hC5C5_0001};
        refresh_fifo();
        apply_stimulus(32'h0000_2000, 32'd2);
        run_reply(7, 0);
        check_reply("t5", 2, 32'h0000_2000);
        if (tx_cyc.size() >= 7)
            check_output("t5_pad_gap", 64'(tx_cyc[6] - tx_cyc[5]), 64'd17);
        fifo_q.push_back(32'hC5C5_0002);
        refresh_fifo();
        repeat (4) tick();
        check_output("t5_late_word_kept", 64'(fifo_q.size()), 64'd1);
        check_output("t5_no_extra_tx", 64'(tx_q.size()), 64'd7);
        check_output("t5_idle_w_enable", w_enable, 0);

        // 6: asynchronous reset in the middle of the data phase
        $display("[TB] reset during data phase");
        fifo_q.delete();
        refresh_fifo();
        clear_log();
        apply_stimulus(32'h0000_3000, 32'd3);
        run_reply(5, 0);
        fifo_q.push_back(32'hD6D6_0001);
        refresh_fifo();
        #1;
        check_output("t6_pre_w_enable", w_enable, 1);
        check_output("t6_pre_rd_data_re", rd_data_re, 1);
        check_output("t6_pre_w_data", w_data, 32'hD6D6_0001);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_w_enable", w_enable, 0);
        check_output("t6_rst_rd_data_re", rd_data_re, 0);
        check_output("t6_rst_w_data", w_data, 0);
        check_output("t6_rst_w_req", w_req, 0);
        check_output("t6_rst_rd_ctrl_we", rd_ctrl_we, 0);
        check_output("t6_rst_rd_ctrl_in", rd_ctrl_in, 0);
        check_output("t6_rst_r_ack", r_ack, 1);
        check_output("t6_rst_drop_cnt", drop_cnt, 0);
        fifo_q.delete();
        refresh_fifo();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        exp_data = '{32'hE0E0_0001};
        fifo_q = exp_data;
        refresh_fifo();
        apply_stimulus(32'h0000_4000, 32'd1);
        run_reply(6, 1);
        check_output("t6_cmd_count", 64'(cmd_cnt), 64'd1);
        check_output("t6_cmd_value", last_cmd, 40'h00_0000_8000);
        check_reply("t6", 1, 32'h0000_4000);
        check_output("t6_drop_cnt", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
